// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback port arbiter.
package wb_pkg;
  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StStall,
    StBubble
  } wb_state_e;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// MDU result handshake into the writeback arbiter.
interface wb_port_arbiter_if;
  import wb_pkg::*;

  logic                  valid;
  logic                  ready;
  logic [XLEN-1:0]       result;
  logic [REG_ADDR_W-1:0] addr;

  modport master (output valid, result, addr, input ready);
  modport slave  (input valid, result, addr, output ready);
endinterface

// File: rtl/wb_fifo.sv
// Synchronous MDU result FIFO exposing per-entry valid/addr for hazard queries.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [XLEN-1:0]       push_data,
  input  logic [REG_ADDR_W-1:0] push_addr,
  output logic                  full,
  output logic                  full_next,
  output logic                  empty,
  output logic [XLEN-1:0]       head_data,
  output logic [REG_ADDR_W-1:0] head_addr,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [REG_ADDR_W-1:0] entry_addr [DEPTH]
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]       data_q [DEPTH];
  logic [REG_ADDR_W-1:0] addr_q [DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         count_q, count_d;

  assign count_d   = count_q + CW'(push) - CW'(pop);
  assign full      = (count_q == CW'(DEPTH));
  assign full_next = (count_d == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = data_q[rptr_q];
  assign head_addr = addr_q[rptr_q];
  assign entry_addr = addr_q;

  // Entry i is live when its distance from the read pointer is below the count.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = CW'(PW'(PW'(i) - rptr_q)) < count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wptr_q] <= push_data;
      addr_q[wptr_q] <= push_addr;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between MEM/WB writeback and buffered MDU results,
// forcing one-cycle pipeline stalls when the buffer fills or its head starves.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       pipe_result_i,
  input  logic [REG_ADDR_W-1:0] pipe_addr_i,
  input  logic                  pipe_we_i,
  wb_port_arbiter_if.slave      mdu,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_addr_o,
  output logic [XLEN-1:0]       rf_data_o,
  output logic                  stall_o,
  input  logic [REG_ADDR_W-1:0] query_addr_i,
  output logic                  query_hit_o
);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic                  pipe_eff, push, pop;
  logic                  full, full_next, empty;
  logic [XLEN-1:0]       head_data;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [FIFO_DEPTH-1:0] entry_valid;
  logic [REG_ADDR_W-1:0] entry_addr [FIFO_DEPTH];
  logic [SW-1:0]         starve_q, starve_d;
  wb_state_e             state_q, state_d;
  logic                  rf_we_q;
  logic [REG_ADDR_W-1:0] rf_addr_q;
  logic [XLEN-1:0]       rf_data_q;

  assign pipe_eff  = pipe_we_i && (pipe_addr_i != '0);
  assign mdu.ready = ~full;
  // x0 results complete the handshake but are dropped.
  assign push      = mdu.valid && mdu.ready && (mdu.addr != '0);
  assign pop       = ~empty && ~pipe_eff;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .push_data   (mdu.result),
    .push_addr   (mdu.addr),
    .full        (full),
    .full_next   (full_next),
    .empty       (empty),
    .head_data   (head_data),
    .head_addr   (head_addr),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  always_comb begin
    starve_d = starve_q;
    if (pop || empty) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // A saturated counter left over from a violated bubble re-requests immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (full_next || (starve_d >= SW'(STARVE_LIMIT - 1))) state_d = StStall;
      end
      StStall:  state_d = StBubble;
      StBubble: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    query_hit_o = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == query_addr_i)) query_hit_o = 1'b1;
    end
    if (query_addr_i == '0) query_hit_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      starve_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rf_we_q  <= pipe_eff || pop;
      if (pipe_eff) begin
        rf_addr_q <= pipe_addr_i;
        rf_data_q <= pipe_result_i;
      end else begin
        rf_addr_q <= head_addr;
        rf_data_q <= head_data;
      end
    end
  end

  assign stall_o   = (state_q == StStall);
  assign rf_we_o   = rf_we_q;
  assign rf_addr_o = rf_addr_q;
  assign rf_data_o = rf_data_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter (FIFO_DEPTH = 2, STARVE_LIMIT = 4).
module tb_wb_port_arbiter;
  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [63:0] pipe_result;
  logic [4:0]  query_addr;
  logic        query_hit;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [63:0] rf_data;
  logic        stall;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter_if mdu_if ();

  wb_port_arbiter #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_result_i (pipe_result),
    .pipe_addr_i   (pipe_addr),
    .pipe_we_i     (pipe_we),
    .mdu           (mdu_if),
    .rf_we_o       (rf_we),
    .rf_addr_o     (rf_addr),
    .rf_data_o     (rf_data),
    .stall_o       (stall),
    .query_addr_i  (query_addr),
    .query_hit_o   (query_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        pwe;
    logic [4:0]  paddr;
    logic [63:0] pdata;
    logic        mv;
    logic [4:0]  maddr;
    logic [63:0] mdata;
    logic [4:0]  qaddr;
    logic        cc;     // check ready/hit before the edge
    logic        ready;
    logic        hit;
    logic        we;
    logic        ad;     // check rf_addr/rf_data even when rf_we is 0
    logic [4:0]  addr;
    logic [63:0] data;
    logic        stall;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic pwe, input logic [4:0] pa,
                              input logic [63:0] pd, input logic mv, input logic [4:0] ma,
                              input logic [63:0] md, input logic [4:0] q, input logic cc,
                              input logic rdy, input logic hit, input logic we, input logic ad,
                              input logic [4:0] a, input logic [63:0] d, input logic st);
    vec_t v;
    v.rst = r;  v.pwe = pwe; v.paddr = pa; v.pdata = pd; v.mv = mv; v.maddr = ma;
    v.mdata = md; v.qaddr = q; v.cc = cc; v.ready = rdy; v.hit = hit; v.we = we;
    v.ad = ad; v.addr = a; v.data = d; v.stall = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic pwe, input logic [4:0] pa,
                       input logic [63:0] pd, input logic mv, input logic [4:0] ma,
                       input logic [63:0] md);
    rst = r; pipe_we = pwe; pipe_addr = pa; pipe_result = pd;
    mdu_if.valid = mv; mdu_if.addr = ma; mdu_if.result = md;
  endtask

  task automatic cyc(input logic pwe, input logic [4:0] pa, input logic [63:0] pd,
                     input logic mv, input logic [4:0] ma, input logic [63:0] md);
    drive(1'b0, pwe, pa, pd, mv, ma, md);
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.rst, v.pwe, v.paddr, v.pdata, v.mv, v.maddr, v.mdata);
    query_addr = v.qaddr;
    #4;
    if (v.cc) begin
      check($sformatf("v%0d mdu_ready", idx), 64'(mdu_if.ready), 64'(v.ready));
      check($sformatf("v%0d query_hit", idx), 64'(query_hit), 64'(v.hit));
    end
    @(posedge clk);
    #1;
    check($sformatf("v%0d rf_we", idx), 64'(rf_we), 64'(v.we));
    check($sformatf("v%0d stall", idx), 64'(stall), 64'(v.stall));
    if (v.we || v.ad) begin
      check($sformatf("v%0d rf_addr", idx), 64'(rf_addr), 64'(v.addr));
      check($sformatf("v%0d rf_data", idx), rf_data, v.data);
    end
  endtask

  initial begin
    int found;
    //            rst pwe pa  pdata    mv ma  mdata     q  cc rdy hit we ad a   data     st
    tbl[0]  = mk(1, 0, 0,  0,       0, 0,  0,        0, 0, 0, 0,  0, 1, 0,  0,       0);
    tbl[1]  = mk(1, 0, 0,  0,       0, 0,  0,        0, 1, 1, 0,  0, 1, 0,  0,       0);
    tbl[2]  = mk(0, 1, 5,  'h11,    0, 0,  0,        5, 1, 1, 0,  1, 0, 5,  'h11,    0);
    tbl[3]  = mk(0, 1, 6,  'h22,    0, 0,  0,        6, 1, 1, 0,  1, 0, 6,  'h22,    0);
    tbl[4]  = mk(0, 0, 0,  0,       0, 0,  0,        0, 1, 1, 0,  0, 0, 0,  0,       0);
    tbl[5]  = mk(0, 0, 0,  0,       1, 7,  'hABCD,   7, 1, 1, 0,  0, 0, 0,  0,       0);
    tbl[6]  = mk(0, 0, 0,  0,       0, 0,  0,        7, 1, 1, 1,  1, 0, 7,  'hABCD,  0);
    tbl[7]  = mk(0, 0, 0,  0,       0, 0,  0,        7, 1, 1, 0,  0, 0, 0,  0,       0);
    tbl[8]  = mk(0, 1, 10, 'h100,   1, 8,  'h808,    8, 1, 1, 0,  1, 0, 10, 'h100,   0);
    tbl[9]  = mk(0, 1, 11, 'h101,   1, 9,  'h909,    8, 1, 1, 1,  1, 0, 11, 'h101,   1);
    tbl[10] = mk(0, 1, 12, 'h102,   0, 0,  0,        9, 1, 0, 1,  1, 0, 12, 'h102,   0);
    tbl[11] = mk(0, 0, 0,  0,       0, 0,  0,        8, 1, 0, 1,  1, 0, 8,  'h808,   0);
    tbl[12] = mk(0, 1, 13, 'h103,   0, 0,  0,        8, 1, 1, 0,  1, 0, 13, 'h103,   0);
    tbl[13] = mk(0, 1, 14, 'h104,   0, 0,  0,        9, 1, 1, 1,  1, 0, 14, 'h104,   0);
    tbl[14] = mk(0, 1, 15, 'h105,   0, 0,  0,        9, 1, 1, 1,  1, 0, 15, 'h105,   1);
    tbl[15] = mk(0, 1, 16, 'h106,   0, 0,  0,        9, 1, 1, 1,  1, 0, 16, 'h106,   0);
    tbl[16] = mk(0, 0, 0,  0,       0, 0,  0,        9, 1, 1, 1,  1, 0, 9,  'h909,   0);
    tbl[17] = mk(0, 0, 0,  0,       0, 0,  0,        9, 1, 1, 0,  0, 0, 0,  0,       0);
    tbl[18] = mk(0, 1, 0,  'hBEEF,  1, 0,  'hDEAD,   0, 1, 1, 0,  0, 0, 0,  0,       0);
    tbl[19] = mk(0, 0, 0,  0,       0, 0,  0,        0, 1, 1, 0,  0, 0, 0,  0,       0);
    tbl[20] = mk(0, 1, 20, 'h200,   1, 21, 'h211,    21, 1, 1, 0, 1, 0, 20, 'h200,   0);
    tbl[21] = mk(0, 1, 22, 'h202,   1, 23, 'h233,    21, 1, 1, 1, 1, 0, 22, 'h202,   1);
    tbl[22] = mk(1, 1, 24, 'h204,   0, 0,  0,        23, 1, 0, 1, 0, 1, 0,  0,       0);
    tbl[23] = mk(0, 0, 0,  0,       0, 0,  0,        21, 1, 1, 0, 0, 0, 0,  0,       0);
    tbl[24] = mk(0, 0, 0,  0,       0, 0,  0,        23, 1, 1, 0, 0, 0, 0,  0,       0);

    for (int i = 0; i < NV; i++) apply(tbl[i], i);

    // Starvation: one entry behind continuous pipeline writes.
    query_addr = 5'd7;
    cyc(1, 2, 'h300, 1, 7, 'h77);
    found = -1;
    for (int k = 0; k < 8 && found < 0; k++) begin
      cyc(1, 3, 64'h301 + 64'(k), 0, 0, 0);
      if (stall) found = k;
    end
    check("starve stall cycle", 64'(found), 64'd2);
    cyc(1, 4, 'h400, 0, 0, 0);
    check("starve stall width", 64'(stall), 64'd0);
    check("starve stall-cycle rf_addr", 64'(rf_addr), 64'd4);
    cyc(0, 0, 0, 0, 0, 0);
    check("starve drain rf_we", 64'(rf_we), 64'd1);
    check("starve drain rf_addr", 64'(rf_addr), 64'd7);
    check("starve drain rf_data", rf_data, 64'h77);

    // Bubble contract violation: pipeline still wins, then an immediate re-request.
    query_addr = 5'd3;
    cyc(1, 2, 'h500, 1, 3, 'h33);
    found = -1;
    for (int k = 0; k < 8 && found < 0; k++) begin
      cyc(1, 2, 64'h510 + 64'(k), 0, 0, 0);
      if (stall) found = k;
    end
    check("violation first stall cycle", 64'(found), 64'd2);
    cyc(1, 4, 'h501, 0, 0, 0);
    cyc(1, 5, 'h502, 0, 0, 0);
    check("violation bubble rf_addr", 64'(rf_addr), 64'd5);
    check("violation bubble rf_data", rf_data, 64'h502);
    check("violation bubble stall", 64'(stall), 64'd0);
    #4;
    check("violation entry still queued", 64'(query_hit), 64'd1);
    cyc(1, 6, 'h503, 0, 0, 0);
    check("violation re-request stall", 64'(stall), 64'd1);
    cyc(1, 7, 'h504, 0, 0, 0);
    check("violation re-request width", 64'(stall), 64'd0);
    cyc(0, 0, 0, 0, 0, 0);
    check("violation drain rf_we", 64'(rf_we), 64'd1);
    check("violation drain rf_addr", 64'(rf_addr), 64'd3);
    check("violation drain rf_data", rf_data, 64'h33);
    cyc(0, 0, 0, 0, 0, 0);
    check("violation idle rf_we", 64'(rf_we), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between in-order pipeline writeback (MEM/WB register output) and the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a small FIFO and drained into idle writeback slots. When the FIFO fills or its head starves, the block requests a one-cycle pipeline stall to create a free slot. It sits between the MEM/WB stage, the MDU and the register file, and exposes a pending-destination query for decode hazard checks.

## Interface
- XLEN, 64, datapath width
- FIFO_DEPTH, 2, MDU result buffer entries (power of 2, ≥2)
- STARVE_LIMIT, 4, cycles a non-empty FIFO may wait before forcing a stall (≥2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pipe_result_i  in  XLEN  writeback data from MEM/WB
- pipe_addr_i  in  5  writeback rd from MEM/WB
- pipe_we_i  in  1  writeback enable from MEM/WB
- mdu_valid_i  in  1  MDU result valid
- mdu_ready_o  out  1  FIFO can accept (= not full)
- mdu_result_i  in  XLEN  MDU result
- mdu_addr_i  in  5  MDU rd
- rf_we_o  out  1  register-file write enable (registered)
- rf_addr_o  out  5  register-file write address (registered)
- rf_data_o  out  XLEN  register-file write data (registered)
- stall_o  out  1  pipeline stall request to MEM/WB (registered)
- query_addr_i  in  5  decode register to check
- query_hit_o  out  1  query_addr_i nonzero and matches a valid FIFO entry (combinational)

## Operation
- Enqueue on mdu_valid_i && mdu_ready_o. mdu_addr_i == 0: handshake completes, nothing stored.
- Pipeline write is effective when pipe_we_i && pipe_addr_i != 0. Effective pipeline writes always win the port.
- FIFO dequeues the head when non-empty and no effective pipeline write is present in that cycle.
- Same-cycle enqueue and dequeue are legal at any non-full count; count is unchanged. No bypass: an entry enqueued in cycle N dequeues at N+1 at the earliest.
- Starve counter: clears on dequeue or when the FIFO is empty; otherwise increments and saturates at STARVE_LIMIT.
- FSM:
  - IDLE → STALL when FIFO full (after this cycle's update) or counter reaches STARVE_LIMIT-1.
  - STALL: stall_o = 1 → BUBBLE.
  - BUBBLE: pipe_we_i is 0 by contract, so the head dequeues → IDLE.
  - No new request is raised while in STALL or BUBBLE.
- Ordering: the block never reorders writes to the same rd. Decode must hold any instruction whose rs or rd gets query_hit_o.

## Timing
- Reset: rf_we_o = 0, rf_addr_o = 0, rf_data_o = 0, stall_o = 0, FIFO empty (mdu_ready_o = 1, query_hit_o = 0), counter 0, FSM IDLE.
- Latency: one cycle from a granted source to the rf_* outputs. rf_we_o = 0 in cycles with no grant; rf_addr_o and rf_data_o are don't-care then.
- stall_o is high for exactly one cycle per request. The forced dequeue occurs the cycle after stall_o.
- If pipe_we_i = 1 during BUBBLE (contract violation), the pipeline still wins, the FSM returns to IDLE, and the counter logic re-requests.
- rst asserted mid-operation discards FIFO contents and any pending stall on the next edge.

## Structure
- Shared package wb_pkg: XLEN, REG_ADDR_W = 5, FSM state encoding (IDLE, STALL, BUBBLE).
- Sub-module wb_fifo: a synchronous FIFO with push, pop, full, empty, per-entry valid/addr visibility for the query compare.

## Test plan
- Pipeline writes only (x5 = 0x11, x6 = 0x22 on consecutive cycles) → rf_we_o pulses one cycle later with the same values; stall_o stays 0.
- MDU result x7 = 0xABCD while the pipeline is idle → rf write x7 = 0xABCD two cycles after the handshake. query_hit_o for x7 is 1 only while the entry is buffered.
- Continuous pipeline writes, MDU pushes x8 then x9 (FIFO_DEPTH = 2) → mdu_ready_o = 0, stall_o for one cycle, x8 written in the bubble, x9 drained by a second stall.
- One MDU entry with pipeline writes every cycle → stall_o asserted at counter = 3 (STARVE_LIMIT = 4), entry written the following cycle.
- MDU push to x0 and pipeline write to x0 → no rf_we_o, no FIFO occupancy.
- rst during the STALL state with 2 entries buffered → next cycle all outputs 0, mdu_ready_o = 1, no write of the buffered entries.
